// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one 8-op unsigned ALU between NREQ requesters.
// One request in flight: IDLE grants, EXEC computes, RESP holds the tagged result.
module alu_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_y,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr;
  logic [NREQ-1:0]   grant_oh;
  logic [IDW-1:0]    grant_id;
  logic              grant_any;
  logic [2:0]        sel_op;
  logic [W-1:0]      sel_a, sel_b;
  logic [2:0]        op_p0;
  logic [W-1:0]      a_p0, b_p0;
  logic [IDW-1:0]    id_p0;
  logic [IDW:0]      rr_sum;
  logic [IDW:0]      rr_nxt;

  function automatic logic [W-1:0] alu_y(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~a;
      3'b011:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return (b == '0) ? '0 : a / b;
      default: return (b == '0) ? '0 : a % b;
    endcase
  endfunction

  function automatic logic alu_err(input logic [2:0] op, input logic [W-1:0] b);
    return (op[2:1] == 2'b11) && (b == '0);
  endfunction

  // Rotating priority scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    rr_sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (rr_sum >= (IDW+1)'(NREQ)) rr_sum = rr_sum - (IDW+1)'(NREQ);
      if (!grant_any && req_valid[rr_sum[IDW-1:0]]) begin
        grant_any                  = 1'b1;
        grant_oh[rr_sum[IDW-1:0]]  = 1'b1;
        grant_id                   = rr_sum[IDW-1:0];
      end
    end
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[W*i +: W];
        sel_b  = req_b[W*i +: W];
      end
    end
  end

  // req_ready is forced low while reset is asserted so no grant leaks out.
  assign req_ready = (state_q == IDLE && rst_n) ? grant_oh : '0;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_comb begin
    rr_nxt = {1'b0, id_p0} + (IDW+1)'(1);
    if (rr_nxt >= (IDW+1)'(NREQ)) rr_nxt = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RESP && rsp_ready) rr_ptr <= rr_nxt[IDW-1:0];
    end
  end

  // Stage p0: request capture on accept; requester may change inputs afterwards.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && grant_any) begin
      op_p0 <= sel_op;
      a_p0  <= sel_a;
      b_p0  <= sel_b;
      id_p0 <= grant_id;
    end
  end

  // Stage p1: ALU result registered in EXEC, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id  <= '0;
      rsp_y   <= '0;
      rsp_err <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_id  <= id_p0;
      rsp_y   <= alu_y(op_p0, a_p0, b_p0);
      rsp_err <= alu_err(op_p0, b_p0);
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: stimulus pushes expected responses,
// a monitor pops and compares on every response handshake.
module tb_alu_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_op;
  logic [7:0]  req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id, rsp_y;
  logic        rsp_err, busy;

  typedef struct { int id; int y; int err; } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = -1;

  alu_rr_sched #(.NREQ(4), .W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU, 2-bit unsigned; returns {err, y}.
  function automatic exp_t model(input int id, input int op, input int a, input int b);
    exp_t e;
    e.id = id; e.err = 0;
    case (op)
      0: e.y = a & b;
      1: e.y = a | b;
      2: e.y = 3 - a;
      3: e.y = (a + b) % 4;
      4: e.y = (a - b + 4) % 4;
      5: e.y = (a * b) % 4;
      6: begin if (b == 0) begin e.y = 0; e.err = 1; end else e.y = a / b; end
      default: begin if (b == 0) begin e.y = 0; e.err = 1; end else e.y = a % b; end
    endcase
    return e;
  endfunction

  task automatic set_req(input int i, input int op, input int a, input int b);
    req_valid[i]      = 1'b1;
    req_op[3*i +: 3]  = 3'(op);
    req_a[2*i +: 2]   = 2'(a);
    req_b[2*i +: 2]   = 2'(b);
  endtask

  task automatic push_model(input int i);
    q.push_back(model(i, int'(req_op[3*i +: 3]), int'(req_a[2*i +: 2]), int'(req_b[2*i +: 2])));
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int n = 0; n < 20 && g < 0; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
    end
  endtask

  task automatic accept_next(input int exp_id, input bit spacing);
    int g;
    wait_grant(g);
    chk("grant_id", g, exp_id);
    if (g >= 0) begin
      push_model(g);
      if (spacing && last_cyc >= 0) chk("accept_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input int id, input int op, input int a, input int b,
                      input int hy, input int herr);
    int g;
    exp_t e;
    @(posedge clk); #1;
    set_req(id, op, a, b);
    wait_grant(g);
    chk("send_grant", g, id);
    if (g >= 0) begin
      if (hy < 0) push_model(g);
      else begin e.id = id; e.y = hy; e.err = herr; q.push_back(e); end
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 60, 1);
  endtask

  // Monitor: every response handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_y", rsp_y, e.y);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  initial begin
    int n;
    exp_t e;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;

    // T2: single request, latency
    @(posedge clk); #1;
    set_req(1, 3, 3, 2);
    #1 chk("t2_ready_same_cycle", req_ready, 4'b0010);
    @(negedge clk);
    e.id = 1; e.y = 1; e.err = 0; q.push_back(e);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_valid_after1", rsp_valid, 0);
    chk("t2_busy_exec", busy, 1);
    @(negedge clk);
    chk("t2_valid_after2", rsp_valid, 1);
    drain();

    // T3: full op sweep from requester 0, plus hand-computed corner cases
    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          send(0, op, a, b, -1, 0);
    send(0, 6, 3, 0, 0, 1);
    send(0, 4, 0, 1, 3, 0);
    send(0, 5, 3, 3, 1, 0);
    send(0, 2, 1, 0, 2, 0);
    drain();

    // T4: round robin with all valid (rr_ptr brought to 0 first)
    send(3, 1, 1, 2, 3, 0);
    drain();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_req(i, 3, i, 1);
    last_cyc = -1;
    accept_next(0, 1); accept_next(1, 1); accept_next(2, 1);
    accept_next(3, 1); accept_next(0, 1); accept_next(1, 1);
    req_valid = '0;
    drain();

    // T5: backpressure
    rsp_ready = 1'b0;
    send(3, 3, 2, 3, 1, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) set_req(i, 0, 3, i);
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk("t5_rsp_seen", rsp_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_id", rsp_id, 3);
      chk("t5_hold_y", rsp_y, 1);
      chk("t5_hold_err", rsp_err, 0);
      chk("t5_hold_ready", req_ready, 0);
      chk("t5_hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    accept_next(0, 0);
    req_valid = '0;
    drain();

    // T6: skip invalid requesters, rr_ptr=3
    send(2, 0, 3, 1, 1, 0);
    drain();
    @(posedge clk); #1;
    set_req(0, 5, 2, 3);
    set_req(2, 7, 3, 2);
    accept_next(0, 0); accept_next(2, 0); accept_next(0, 0);
    req_valid = '0;
    drain();

    // T1: reset mid-RESP discards the result; next grant goes to req0
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    set_req(1, 3, 1, 1);
    begin
      int g;
      wait_grant(g);
      chk("t1_grant", g, 1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk("t1_in_resp", rsp_valid, 1);
    for (int i = 0; i < 4; i++) set_req(i, 1, i, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", rsp_valid, 0);
    chk("t1_rst_ready", req_ready, 0);
    chk("t1_rst_busy", busy, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    accept_next(0, 0);
    req_valid = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
